// File: rtl/sha3_hw_seq_if.sv
// Valid-hold host bus between the SHA3 hardware sequencer and the SHA3 wrapper register path.
// Signal names follow the sequencer's point of view.
interface sha3_hw_seq_if;
  logic        vh_dv_o;
  logic        vh_write_o;
  logic [31:0] vh_addr_o;
  logic [31:0] vh_wdata_o;
  logic        vh_hld_i;
  logic [31:0] vh_rdata_i;
  logic        vh_err_i;

  modport master (
    output vh_dv_o, vh_write_o, vh_addr_o, vh_wdata_o,
    input  vh_hld_i, vh_rdata_i, vh_err_i
  );

  modport slave (
    input  vh_dv_o, vh_write_o, vh_addr_o, vh_wdata_o,
    output vh_hld_i, vh_rdata_i, vh_err_i
  );
endinterface

// File: rtl/sha3_hw_seq.sv
// Round-robin sequencer that runs complete SHA3 jobs for NUM_REQ requesters over the valid-hold bus.
// Define SHA3_HW_SEQ_POLL_TIMEOUT_EN to bound the STATUS poll loop to POLL_LIMIT reads.
module sha3_hw_seq #(
  parameter int          NUM_REQ    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter logic [31:0] CFG_OFS    = 32'h14,
  parameter logic [31:0] CMD_OFS    = 32'h18,
  parameter logic [31:0] STATUS_OFS = 32'h1C,
  parameter logic [31:0] STATE_OFS  = 32'h400,
  parameter logic [31:0] FIFO_OFS   = 32'h800,
  parameter int          POLL_LIMIT = 4096
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [2*NUM_REQ-1:0]  mode_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  input  logic [NUM_REQ-1:0]    msg_valid_i,
  input  logic [32*NUM_REQ-1:0] msg_data_i,
  input  logic [NUM_REQ-1:0]    msg_last_i,
  output logic                  msg_ready_o,
  output logic                  dig_valid_o,
  output logic [31:0]           dig_data_o,
  output logic                  dig_last_o,
  input  logic                  dig_ready_i,
  sha3_hw_seq_if.master         vh,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

  localparam logic [31:0] CMD_START = 32'h1D;
  localparam logic [31:0] CMD_PROC  = 32'h2E;
  localparam logic [31:0] CMD_DONE  = 32'h16;

  if (NUM_REQ < 2 || NUM_REQ > 4 || POLL_LIMIT < 1 || POLL_LIMIT > 8191) begin : g_param_check
    $error("sha3_hw_seq: NUM_REQ must be 2..4 and POLL_LIMIT 1..8191");
  end

  typedef enum logic [3:0] {
    IDLE, CFG0, CFG1, START, MSG, PROC, POLL, READ, PRESENT, DONE, ERR
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, owner_q, win_idx;
  logic               win_found;
  logic [1:0]         mode_q;
  logic [3:0]         k_q;
  logic [31:0]        dig_data_q;
  logic               err_q;
  logic               dv, wr, xfer, k_inc, dig_load, poll_expired, in_job;
  logic [31:0]        addr, wdata;

  // kstrength lives in bits [3:1]; mode bits [5:4] stay zero.
  function automatic logic [31:0] cfg_word(input logic [1:0] m);
    cfg_word = {28'd0, {1'b0, m} + 3'd1, 1'b0};
  endfunction

  // Index of the final digest word: 7/8/12/16 words for SHA3-224/256/384/512.
  function automatic logic [3:0] dig_last_idx(input logic [1:0] m);
    case (m)
      2'd0:    dig_last_idx = 4'd6;
      2'd1:    dig_last_idx = 4'd7;
      2'd2:    dig_last_idx = 4'd11;
      default: dig_last_idx = 4'd15;
    endcase
  endfunction

  always_comb begin
    int j;
    win_found = 1'b0;
    win_idx   = last_q;
    j         = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = int'(last_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!win_found && req_i[j]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    dv          = 1'b0;
    wr          = 1'b0;
    addr        = '0;
    wdata       = '0;
    msg_ready_o = 1'b0;
    k_inc       = 1'b0;
    dig_load    = 1'b0;

    case (state_q)
      CFG0, CFG1: begin
        dv = 1'b1; wr = 1'b1; addr = BASE_ADDR + CFG_OFS; wdata = cfg_word(mode_q);
      end
      START:       begin dv = 1'b1; wr = 1'b1; addr = BASE_ADDR + CMD_OFS; wdata = CMD_START; end
      MSG: begin
        dv    = msg_valid_i[owner_q];
        wr    = 1'b1;
        addr  = BASE_ADDR + FIFO_OFS;
        wdata = msg_data_i[32*owner_q +: 32];
      end
      PROC:        begin dv = 1'b1; wr = 1'b1; addr = BASE_ADDR + CMD_OFS; wdata = CMD_PROC; end
      POLL:        begin dv = 1'b1; addr = BASE_ADDR + STATUS_OFS; end
      READ:        begin dv = 1'b1; addr = BASE_ADDR + STATE_OFS + {26'd0, k_q, 2'b00}; end
      DONE, ERR:   begin dv = 1'b1; wr = 1'b1; addr = BASE_ADDR + CMD_OFS; wdata = CMD_DONE; end
      default: ;
    endcase

    xfer = dv && !vh.vh_hld_i;

    case (state_q)
      IDLE:  if (win_found) state_d = CFG0;
      CFG0:  if (xfer) state_d = vh.vh_err_i ? ERR : CFG1;
      CFG1:  if (xfer) state_d = vh.vh_err_i ? ERR : START;
      START: if (xfer) state_d = vh.vh_err_i ? ERR : MSG;
      MSG: begin
        if (xfer) begin
          if (vh.vh_err_i) state_d = ERR;
          else begin
            msg_ready_o = 1'b1;
            if (msg_last_i[owner_q]) state_d = PROC;
          end
        end
      end
      PROC:  if (xfer) state_d = vh.vh_err_i ? ERR : POLL;
      POLL: begin
        if (xfer) begin
          if (vh.vh_err_i)           state_d = ERR;
          else if (vh.vh_rdata_i[2]) state_d = READ;
          else if (poll_expired)     state_d = ERR;
        end
      end
      READ: begin
        if (xfer) begin
          if (vh.vh_err_i) state_d = ERR;
          else begin
            dig_load = 1'b1;
            state_d  = PRESENT;
          end
        end
      end
      PRESENT: begin
        if (dig_ready_i) begin
          if (k_q == dig_last_idx(mode_q)) state_d = DONE;
          else begin
            k_inc   = 1'b1;
            state_d = READ;
          end
        end
      end
      DONE:  if (xfer) state_d = vh.vh_err_i ? ERR : IDLE;
      ERR:   if (xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_q     <= IDX_W'(NUM_REQ - 1);
      owner_q    <= '0;
      mode_q     <= '0;
      k_q        <= '0;
      dig_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= (state_d == ERR) && (state_q != ERR);
      if (state_q == IDLE && win_found) begin
        owner_q <= win_idx;
        last_q  <= win_idx;
        mode_q  <= mode_i[2*win_idx +: 2];
        k_q     <= '0;
      end
      if (k_inc)    k_q        <= k_q + 4'd1;
      if (dig_load) dig_data_q <= vh.vh_rdata_i;
    end
  end

`ifdef SHA3_HW_SEQ_POLL_TIMEOUT_EN
  // Counter is held at zero outside POLL, so every poll phase starts from a fresh count.
  logic [12:0] poll_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                  poll_cnt_q <= '0;
    else if (state_q != POLL)                      poll_cnt_q <= '0;
    else if (xfer && !vh.vh_rdata_i[2])            poll_cnt_q <= poll_cnt_q + 13'd1;
  end

  assign poll_expired = (poll_cnt_q == 13'(POLL_LIMIT - 1));
`else
  assign poll_expired = 1'b0;
`endif

  assign in_job        = (state_q != IDLE) && (state_q != ERR);
  assign gnt_o         = in_job ? (NUM_REQ'(1) << owner_q) : '0;
  assign dig_valid_o   = (state_q == PRESENT);
  assign dig_last_o    = dig_valid_o && (k_q == dig_last_idx(mode_q));
  assign dig_data_o    = dig_data_q;
  assign busy_o        = (state_q != IDLE);
  assign err_o         = err_q;

  assign vh.vh_dv_o    = dv;
  assign vh.vh_write_o = wr;
  assign vh.vh_addr_o  = addr;
  assign vh.vh_wdata_o = wdata;

endmodule

// File: tb/tb_sha3_hw_seq.sv
// Directed bench for sha3_hw_seq with a behavioural SHA3 register-path responder on the valid-hold bus.
module tb_sha3_hw_seq;

  localparam logic [31:0] A_CFG    = 32'h0000_1014;
  localparam logic [31:0] A_CMD    = 32'h0000_1018;
  localparam logic [31:0] A_STATUS = 32'h0000_101C;
  localparam logic [31:0] A_STATE  = 32'h0000_1400;
  localparam logic [31:0] A_FIFO   = 32'h0000_1800;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req = '0;
  logic [3:0]  mode = '0;
  logic [1:0]  gnt;
  logic [1:0]  msg_valid = '0;
  logic [63:0] msg_data = '0;
  logic [1:0]  msg_last = '0;
  logic        msg_ready;
  logic        dig_valid;
  logic [31:0] dig_data;
  logic        dig_last;
  logic        dig_ready = 1'b0;
  logic        busy;
  logic        err;

  sha3_hw_seq_if vif();

  sha3_hw_seq #(.NUM_REQ(2), .POLL_LIMIT(16)) dut (
    .clk(clk), .reset_n(reset_n), .req_i(req), .mode_i(mode), .gnt_o(gnt),
    .msg_valid_i(msg_valid), .msg_data_i(msg_data), .msg_last_i(msg_last),
    .msg_ready_o(msg_ready), .dig_valid_o(dig_valid), .dig_data_o(dig_data),
    .dig_last_o(dig_last), .dig_ready_i(dig_ready), .vh(vif),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Responder state
  bit          hold_en = 0;
  int          poll_needed = 0;
  int          status_reads = 0;
  int          fifo_writes = 0;
  int          err_fifo_idx = 0;
  int          stab_err = 0;
  int          err_pulses = 0;
  int          dig_cycles = 0;
  bit          in_txn = 0;
  int          hold_left = 0;
  logic [64:0] snap;
  logic [31:0] ofs;
  logic [31:0] log_addr[$];
  logic        log_wr[$];
  logic [31:0] log_wdata[$];
  logic [31:0] sent_q[$];
  logic [31:0] exp_addr[$];
  logic        exp_wr[$];
  logic [31:0] exp_wdata[$];

  logic [31:0] cfg_tab [4] = '{32'h2, 32'h4, 32'h6, 32'h8};
  int          n_tab   [4] = '{7, 8, 12, 16};

  initial begin
    vif.vh_hld_i   = 1'b0;
    vif.vh_rdata_i = '0;
    vif.vh_err_i   = 1'b0;
  end

  // Responses are decided on the falling edge so the DUT samples them on the next rising edge.
  always @(negedge clk) begin
    err_pulses += int'(err);
    dig_cycles += int'(dig_valid);
    if (!reset_n || !vif.vh_dv_o) begin
      in_txn = 0; hold_left = 0;
      vif.vh_hld_i = 1'b0; vif.vh_err_i = 1'b0; vif.vh_rdata_i = '0;
    end else begin
      if (!in_txn) begin
        in_txn    = 1;
        hold_left = hold_en ? int'($urandom_range(0, 5)) : 0;
        snap      = {vif.vh_write_o, vif.vh_addr_o, vif.vh_wdata_o};
      end else if ({vif.vh_write_o, vif.vh_addr_o, vif.vh_wdata_o} !== snap) begin
        stab_err++;
      end
      vif.vh_rdata_i = '0;
      vif.vh_err_i   = 1'b0;
      if (hold_left > 0) begin
        vif.vh_hld_i = 1'b1;
        hold_left--;
      end else begin
        vif.vh_hld_i = 1'b0;
        ofs = vif.vh_addr_o - 32'h1000;
        if (!vif.vh_write_o && vif.vh_addr_o == A_STATUS) begin
          vif.vh_rdata_i = (status_reads >= poll_needed) ? 32'h0000_0004 : 32'h0000_0001;
          status_reads++;
        end else if (!vif.vh_write_o && ofs >= 32'h400 && ofs < 32'h440) begin
          vif.vh_rdata_i = 32'h5A00_0000 + (ofs - 32'h400);
        end else if (vif.vh_write_o && vif.vh_addr_o == A_FIFO) begin
          fifo_writes++;
          vif.vh_err_i = (fifo_writes == err_fifo_idx);
        end
        log_addr.push_back(vif.vh_addr_o);
        log_wr.push_back(vif.vh_write_o);
        log_wdata.push_back(vif.vh_wdata_o);
        in_txn = 0;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic obs_pt();
    @(negedge clk); #1;
  endtask

  task automatic clear_logs();
    log_addr.delete(); log_wr.delete(); log_wdata.delete(); sent_q.delete();
    exp_addr.delete(); exp_wr.delete(); exp_wdata.delete();
    status_reads = 0; fifo_writes = 0; err_pulses = 0; dig_cycles = 0; stab_err = 0;
  endtask

  task automatic add_exp(input logic [31:0] a, input logic w, input logic [31:0] d);
    exp_addr.push_back(a); exp_wr.push_back(w); exp_wdata.push_back(d);
  endtask

  task automatic build_exp(input int m, input int npolls);
    add_exp(A_CFG, 1, cfg_tab[m]);
    add_exp(A_CFG, 1, cfg_tab[m]);
    add_exp(A_CMD, 1, 32'h1D);
    foreach (sent_q[i]) add_exp(A_FIFO, 1, sent_q[i]);
    add_exp(A_CMD, 1, 32'h2E);
    for (int i = 0; i < npolls; i++) add_exp(A_STATUS, 0, 32'h0);
    for (int k = 0; k < n_tab[m]; k++) add_exp(A_STATE + 32'(4*k), 0, 32'h0);
    add_exp(A_CMD, 1, 32'h16);
  endtask

  task automatic cmp_log(input string tag);
    int n;
    chk({tag, "_len"}, 32'(log_addr.size()), 32'(exp_addr.size()));
    n = (log_addr.size() < exp_addr.size()) ? log_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), log_addr[i], exp_addr[i]);
      chk($sformatf("%s_wr%0d", tag, i), 32'(log_wr[i]), 32'(exp_wr[i]));
      if (exp_wr[i]) chk($sformatf("%s_wdata%0d", tag, i), log_wdata[i], exp_wdata[i]);
    end
  endtask

  task automatic push_word(input int who, input logic [31:0] d, input logic last);
    bit got = 0;
    msg_valid[who] = 1'b1;
    msg_data[32*who +: 32] = d;
    msg_last[who] = last;
    for (int c = 0; c < 300 && !got; c++) begin
      obs_pt();
      if (msg_ready) got = 1;
    end
    chk("msg_accept", 32'(got), 32'd1);
    sent_q.push_back(d);
    step();
    msg_valid[who] = 1'b0;
    msg_last[who]  = 1'b0;
  endtask

  task automatic collect(input int n, input int stall_k, input int stall_cycles);
    for (int k = 0; k < n; k++) begin
      bit seen = 0;
      for (int c = 0; c < 300 && !seen; c++) begin
        obs_pt();
        if (dig_valid) seen = 1;
      end
      chk($sformatf("dig_seen%0d", k), 32'(seen), 32'd1);
      chk($sformatf("dig_data%0d", k), dig_data, 32'h5A00_0000 + 32'(4*k));
      chk($sformatf("dig_last%0d", k), 32'(dig_last), 32'(k == n - 1));
      if (k == stall_k) begin
        repeat (stall_cycles) step();
        obs_pt();
        chk("stall_valid", 32'(dig_valid), 32'd1);
        chk("stall_data", dig_data, 32'h5A00_0000 + 32'(4*k));
      end
      step();
      dig_ready = 1'b1;
      step();
      dig_ready = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 500 && busy; c++) step();
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ctrl", {25'd0, vif.vh_dv_o, vif.vh_write_o, busy, err, msg_ready, dig_valid, dig_last}, 32'd0);
    chk("rst_dig_data", dig_data, 32'd0);
    chk("rst_addr", vif.vh_addr_o, 32'd0);
    chk("rst_wdata", vif.vh_wdata_o, 32'd0);
    reset_n = 1'b1;
    step();

    // Job 1: both request, index 0 wins; SHA3-256 of one word
    clear_logs();
    poll_needed = 2;
    req  = 2'b11;
    mode = 4'b0101;
    step();
    chk("grant_first", 32'(gnt), 32'b01);
    mode = 4'b1101;
    push_word(0, 32'h0063_6261, 1'b1);
    chk("grant_hold", 32'(gnt), 32'b01);
    collect(8, -1, 0);
    for (int c = 0; c < 50 && gnt != 2'b10; c++) step();
    chk("grant_second", 32'(gnt), 32'b10);
    build_exp(1, 3);
    cmp_log("job1");

    // Job 2: requester 1, SHA3-512, two words, random hold stretching; req dropped mid-job
    clear_logs();
    hold_en = 1;
    poll_needed = 0;
    req = 2'b00;
    push_word(1, 32'h1111_1111, 1'b0);
    push_word(1, 32'h2222_2222, 1'b1);
    chk("grant_after_drop", 32'(gnt), 32'b10);
    collect(16, -1, 0);
    wait_idle("job2_idle");
    chk("hold_stable", 32'(stab_err), 32'd0);
    chk("job2_no_err", 32'(err_pulses), 32'd0);
    build_exp(3, 1);
    cmp_log("job2");
    hold_en = 0;

    // Job 3: bus error on the second FIFO write
    clear_logs();
    err_fifo_idx = 2;
    req  = 2'b01;
    mode = 4'b0000;
    step();
    chk("err_job_grant", 32'(gnt), 32'b01);
    req = 2'b00;
    push_word(0, 32'hAAAA_0001, 1'b0);
    msg_valid[0] = 1'b1;
    msg_data[31:0] = 32'hAAAA_0002;
    msg_last[0] = 1'b1;
    wait_idle("err_idle");
    msg_valid[0] = 1'b0;
    msg_last[0]  = 1'b0;
    step();
    chk("err_pulse", 32'(err_pulses), 32'd1);
    chk("err_no_dig", 32'(dig_cycles), 32'd0);
    chk("err_gnt", 32'(gnt), 32'd0);
    chk("err_log_len", 32'(log_addr.size()), 32'd6);
    chk("err_last_addr", log_addr[log_addr.size()-1], A_CMD);
    chk("err_last_wdata", log_wdata[log_wdata.size()-1], 32'h16);
    err_fifo_idx = 0;

    // Job 4: SHA3-224 with digest backpressure on word 3
    clear_logs();
    req = 2'b01;
    step();
    chk("bp_grant", 32'(gnt), 32'b01);
    req = 2'b00;
    push_word(0, 32'h0BAD_F00D, 1'b1);
    collect(7, 3, 10);
    wait_idle("bp_idle");
    build_exp(0, 1);
    cmp_log("job4");

    // Job 5: reset asserted mid-MSG, pointer returns to NUM_REQ-1
    clear_logs();
    hold_en = 1;
    req = 2'b10;
    step();
    chk("rstjob_grant", 32'(gnt), 32'b10);
    req = 2'b00;
    for (int c = 0; c < 200 && log_addr.size() < 3; c++) step();
    chk("rstjob_reach_msg", 32'(log_addr.size() >= 3), 32'd1);
    msg_valid[1] = 1'b1;
    msg_data[63:32] = 32'h5555_0001;
    step();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_ctrl", {26'd0, vif.vh_dv_o, busy, err, msg_ready, dig_valid, dig_last}, 32'd0);
    chk("mid_rst_dig_data", dig_data, 32'd0);
    msg_valid[1] = 1'b0;
    hold_en = 0;
    step();
    reset_n = 1'b1;
    step();
    clear_logs();
    req = 2'b11;
    step();
    chk("post_rst_grant", 32'(gnt), 32'b01);
    req = 2'b00;
    push_word(0, 32'h0000_0001, 1'b1);
    collect(7, -1, 0);
    wait_idle("post_rst_idle");

`ifdef SHA3_HW_SEQ_POLL_TIMEOUT_EN
    // Job 6: status never squeezes; poll bound ends the job
    clear_logs();
    poll_needed = 1000;
    req = 2'b01;
    step();
    req = 2'b00;
    push_word(0, 32'h0000_0002, 1'b1);
    wait_idle("to_idle");
    step();
    chk("to_status_reads", 32'(status_reads), 32'd16);
    chk("to_err_pulse", 32'(err_pulses), 32'd1);
    chk("to_no_dig", 32'(dig_cycles), 32'd0);
    chk("to_gnt", 32'(gnt), 32'd0);
    poll_needed = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
